// File: rtl/matmul_operand_streamer.sv
// Operand feeder for C = A*B: walks r/c/k with incrementing pointers, reads A and B from
// synchronous scratch ports and streams ordered (a, b) pairs with first/last markers.
module matmul_operand_streamer #(
    parameter int FP_WIDTH = 32,
    parameter int ADDR_W   = 20,
    parameter int DIM_W    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DIM_W-1:0]    dim_m,
    input  logic [DIM_W-1:0]    dim_n,
    input  logic [DIM_W-1:0]    dim_k,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr_a,
    output logic [ADDR_W-1:0]   mem_addr_b,
    input  logic [FP_WIDTH-1:0] mem_rdata_a,
    input  logic [FP_WIDTH-1:0] mem_rdata_b,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [FP_WIDTH-1:0] op_a,
    output logic [FP_WIDTH-1:0] op_b,
    output logic                op_first,
    output logic                op_last,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);
    // Stream handshake: a pair transfers on a cycle where op_valid && op_ready; while
    // op_valid is high and op_ready low, op_a/op_b/op_first/op_last hold their values.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
    localparam int EW = 2 * FP_WIDTH + 2;

    state_t state, state_nx;

    logic [DIM_W-1:0]  m_q, n_q, k_q;
    logic [DIM_W-1:0]  r_cnt, c_cnt, k_cnt;
    logic [ADDR_W-1:0] base_b_q, ptr_a, row_a, ptr_b, col_b;
    logic              rd_q, first_q, last_q;
    logic [EW-1:0]     fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;

    logic [EW-1:0] in_entry, head;
    logic [2:0]    occ;
    logic          pop, push, fifo_pop, issue, k_end, c_end, r_end, zero_dim;

    // Returning read data bypasses the FIFO when it is empty so the pair is visible the
    // same cycle the memory presents it.
    assign in_entry = {mem_rdata_a, mem_rdata_b, first_q, last_q};
    assign head     = (count != 2'd0) ? fifo_mem[rd_ptr] : in_entry;
    assign op_valid = (count != 2'd0) || rd_q;
    assign pop      = op_valid && op_ready;
    assign push     = rd_q && !((count == 2'd0) && pop);
    assign fifo_pop = pop && (count != 2'd0);
    assign occ      = {1'b0, count} + {2'b00, rd_q} - {2'b00, pop};

    assign k_end    = (k_cnt == k_q - DIM_W'(1));
    assign c_end    = (c_cnt == n_q - DIM_W'(1));
    assign r_end    = (r_cnt == m_q - DIM_W'(1));
    assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);
    assign issue    = (state == S_RUN) && (occ < 3'd2);

    assign mem_rd_en  = issue;
    assign mem_addr_a = ptr_a;
    assign mem_addr_b = ptr_b;
    assign {op_a, op_b, op_first, op_last} = op_valid ? head : '0;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // An empty job passes through DRAIN so busy covers one cycle before done.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = zero_dim ? S_DRAIN : S_RUN;
            S_RUN:   if (issue && k_end && c_end && r_end) state_nx = S_DRAIN;
            S_DRAIN: if (occ == 3'd0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0; n_q <= '0; k_q <= '0;
            r_cnt <= '0; c_cnt <= '0; k_cnt <= '0;
            base_b_q <= '0; ptr_a <= '0; row_a <= '0; ptr_b <= '0; col_b <= '0;
        end else if ((state == S_IDLE) && start) begin
            m_q <= dim_m; n_q <= dim_n; k_q <= dim_k;
            r_cnt <= '0; c_cnt <= '0; k_cnt <= '0;
            base_b_q <= base_b; ptr_a <= base_a; row_a <= base_a;
            ptr_b <= base_b; col_b <= base_b;
        end else if (issue) begin
            if (!k_end) begin
                k_cnt <= k_cnt + DIM_W'(1);
                ptr_a <= ptr_a + ADDR_W'(1);
                ptr_b <= ptr_b + ADDR_W'(n_q);
            end else begin
                k_cnt <= '0;
                if (!c_end) begin
                    c_cnt <= c_cnt + DIM_W'(1);
                    ptr_a <= row_a;
                    ptr_b <= col_b + ADDR_W'(1);
                    col_b <= col_b + ADDR_W'(1);
                end else begin
                    c_cnt <= '0;
                    ptr_b <= base_b_q;
                    col_b <= base_b_q;
                    if (!r_end) begin
                        r_cnt <= r_cnt + DIM_W'(1);
                        row_a <= row_a + ADDR_W'(k_q);
                        ptr_a <= row_a + ADDR_W'(k_q);
                    end
                end
            end
        end
    end

    // Clearing rd_q on reset drops any read data still returning from an aborted job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0; first_q <= 1'b0; last_q <= 1'b0;
        end else begin
            rd_q <= issue;
            if (issue) begin
                first_q <= (k_cnt == '0);
                last_q  <= k_end;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0; wr_ptr <= 1'b0; rd_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, fifo_pop};
            if (push)     wr_ptr <= ~wr_ptr;
            if (fifo_pop) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_entry;
    end
endmodule

// File: tb/tb_matmul_operand_streamer.sv
// Bench for matmul_operand_streamer: scratch memory model, directed jobs, a loop-nest
// reference model feeding expected queues, and one per-cycle compare process.
module tb_matmul_operand_streamer;
    localparam int FPW = 32;
    localparam int AW  = 20;
    localparam int DW  = 10;
    localparam int EW  = 2 * FPW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic           start = 1'b0;
    logic [DW-1:0]  dim_m = '0, dim_n = '0, dim_k = '0;
    logic [AW-1:0]  base_a = '0, base_b = '0;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_addr_a, mem_addr_b;
    logic [FPW-1:0] mem_rdata_a, mem_rdata_b;
    logic           op_valid, op_ready, op_first, op_last, busy, done;
    logic [FPW-1:0] op_a, op_b;
    logic [1:0]     dbg_state;

    matmul_operand_streamer #(.FP_WIDTH(FPW), .ADDR_W(AW), .DIM_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b),
        .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_first(op_first), .op_last(op_last),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- scratch memory model (1-cycle synchronous read) ----------------
    logic [FPW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata_a <= mem[mem_addr_a[7:0]];
            mem_rdata_b <= mem[mem_addr_b[7:0]];
        end else begin
            mem_rdata_a <= 32'hBADBAD00;
            mem_rdata_b <= 32'hBADBAD01;
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0]   exp_q[$];
    logic [2*AW-1:0] addr_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain loop nest over the row-major layout.
    task automatic build_model(input int m, input int n, input int k, input int ba, input int bb);
        int aa, ab;
        exp_q.delete();
        addr_q.delete();
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                for (int kk = 0; kk < k; kk++) begin
                    aa = ba + r * k + kk;
                    ab = bb + kk * n + c;
                    exp_q.push_back({mem[aa], mem[ab], (kk == 0), (kk == k - 1)});
                    addr_q.push_back({AW'(aa), AW'(ab)});
                end
    endtask

    // ---------------- per-cycle compare process ----------------
    int e0 = 0;
    int hs_cnt, done_cnt, rd_cnt, valid_cnt, busy_cnt, first_valid, done_cyc, outstanding;
    int rel, occ_now;
    logic hs, stall_prev = 1'b0;
    logic [EW-1:0]   prev_out, exp_e;
    logic [2*AW-1:0] exp_addr;

    always @(negedge clk) begin
        rel = cyc - e0 + 1;
        if (reset) begin
            stall_prev  = 1'b0;
            outstanding = 0;
        end else begin
            hs = op_valid && op_ready;
            if (busy) busy_cnt++;
            if (op_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = rel;
            end
            if (stall_prev)
                chk("stall_hold", {13'b0, op_valid, op_a, op_b, op_first, op_last}, {13'b0, 1'b1, prev_out});
            if (mem_rd_en) begin
                rd_cnt++;
                occ_now = outstanding - (hs ? 1 : 0) + 1;
                chk("fifo_occupancy", 80'(occ_now <= 2), 80'(1));
                if (addr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_read: got addr %0h/%0h expected no read", mem_addr_a, mem_addr_b);
                end else begin
                    exp_addr = addr_q.pop_front();
                    chk("read_addr", {40'b0, mem_addr_a, mem_addr_b}, {40'b0, exp_addr});
                end
            end
            if (hs) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_pair: got %0h/%0h expected no pair", op_a, op_b);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("pair", {14'b0, op_a, op_b, op_first, op_last}, {14'b0, exp_e});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
                chk("busy_at_done", 80'(busy), 80'(0));
            end
            stall_prev  = op_valid && !op_ready;
            prev_out    = {op_a, op_b, op_first, op_last};
            outstanding = outstanding + (mem_rd_en ? 1 : 0) - (hs ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    bit ready_rand = 1'b0;
    initial begin
        op_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            op_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_stats();
        hs_cnt = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        first_valid = -1; done_cyc = -1;
    endtask

    task automatic pulse_start(input int m, input int n, input int k, input int ba, input int bb);
        dim_m = DW'(m); dim_n = DW'(n); dim_k = DW'(k);
        base_a = AW'(ba); base_b = AW'(bb);
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        start = 1'b0;
    endtask

    task automatic launch_job(input int m, input int n, input int k, input int ba, input int bb,
                              input bit rand_ready, input int mid_start_at);
        int p;
        bit got;
        p = m * n * k;
        ready_rand = rand_ready;
        clear_stats();
        pulse_start(m, n, k, ba, bb);
        got = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            if (done_cnt != 0) begin
                got = 1'b1;
                break;
            end
            if (i == mid_start_at) begin
                start = 1'b1;
                dim_m = 3; dim_n = 3; dim_k = 3; base_a = 100; base_b = 200;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no done expected done for %0dx%0dx%0d", m, n, k);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("pair_count", 80'(hs_cnt), 80'(p));
        chk("read_count", 80'(rd_cnt), 80'(p));
        chk("done_count", 80'(done_cnt), 80'(1));
        chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
        chk("addr_q_drained", 80'(addr_q.size()), 80'(0));
        if (p == 0) begin
            chk("zero_busy_cycles", 80'(busy_cnt), 80'(1));
            chk("zero_done_cycle", 80'(done_cyc), 80'(2));
            chk("zero_valid_cycles", 80'(valid_cnt), 80'(0));
        end else if (!rand_ready) begin
            chk("first_valid_cycle", 80'(first_valid), 80'(2));
            chk("done_cycle", 80'(done_cyc), 80'(p + 2));
            chk("valid_no_bubbles", 80'(valid_cnt), 80'(p));
            chk("busy_cycles", 80'(busy_cnt), 80'(p + 1));
        end
        ready_rand = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [EW-1:0] pin_t1 [8];
    int g;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0000 + 32'(i);
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[16] = 5; mem[17] = 6; mem[18] = 7; mem[19] = 8;
        pin_t1[0] = {32'd1, 32'd5, 1'b1, 1'b0};
        pin_t1[1] = {32'd2, 32'd7, 1'b0, 1'b1};
        pin_t1[2] = {32'd1, 32'd6, 1'b1, 1'b0};
        pin_t1[3] = {32'd2, 32'd8, 1'b0, 1'b1};
        pin_t1[4] = {32'd3, 32'd5, 1'b1, 1'b0};
        pin_t1[5] = {32'd4, 32'd7, 1'b0, 1'b1};
        pin_t1[6] = {32'd3, 32'd6, 1'b1, 1'b0};
        pin_t1[7] = {32'd4, 32'd8, 1'b0, 1'b1};
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {32'b0, mem_rd_en, mem_addr_a, mem_addr_b, op_valid, op_first, op_last, busy, done, dbg_state}, 80'(0));
        chk("reset_data", {16'b0, op_a, op_b}, 80'(0));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 2x2x2 with full throughput; model pinned to hand-computed pairs
        build_model(2, 2, 2, 0, 16);
        for (int i = 0; i < 8; i++) chk("model_pin_2x2x2", {14'b0, exp_q[i]}, {14'b0, pin_t1[i]});
        launch_job(2, 2, 2, 0, 16, 1'b0, 0);

        // same job under random backpressure
        build_model(2, 2, 2, 0, 16);
        launch_job(2, 2, 2, 0, 16, 1'b1, 0);

        // K=1: every pair is both first and last, B walks base_b+0..3 per row
        build_model(3, 4, 1, 40, 80);
        for (int i = 0; i < 12; i++) begin
            chk("model_pin_k1_baddr", 80'(addr_q[i][AW-1:0]), 80'(80 + i % 4));
            chk("model_pin_k1_tags", 80'(exp_q[i][1:0]), 80'(3));
        end
        launch_job(3, 4, 1, 40, 80, 1'b0, 0);

        // wider wrap pattern under backpressure
        build_model(3, 2, 4, 120, 160);
        launch_job(3, 2, 4, 120, 160, 1'b1, 0);

        // zero dimensions
        build_model(2, 2, 0, 0, 16);
        launch_job(2, 2, 0, 0, 16, 1'b0, 0);
        build_model(0, 3, 3, 0, 16);
        launch_job(0, 3, 3, 0, 16, 1'b0, 0);

        // start while busy is ignored
        build_model(2, 2, 2, 0, 16);
        launch_job(2, 2, 2, 0, 16, 1'b0, 4);

        // reset after the third handshake
        build_model(2, 2, 2, 0, 16);
        ready_rand = 1'b0;
        clear_stats();
        pulse_start(2, 2, 2, 0, 16);
        g = 0;
        while (hs_cnt < 3 && g < 50) begin
            @(posedge clk);
            g++;
        end
        if (hs_cnt < 3) begin
            n_cmp++; n_err++;
            $display("FAIL reset_wait_timeout: got %0d handshakes expected 3", hs_cnt);
        end
        #1 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {32'b0, mem_rd_en, mem_addr_a, mem_addr_b, op_valid, op_first, op_last, busy, done, dbg_state}, 80'(0));
        chk("midreset_data", {16'b0, op_a, op_b}, 80'(0));
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midreset_no_done", 80'(done_cnt), 80'(0));
        chk("midreset_hs_count", 80'(hs_cnt), 80'(3));
        chk("midreset_no_valid", 80'(op_valid), 80'(0));

        build_model(2, 2, 2, 0, 16);
        launch_job(2, 2, 2, 0, 16, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
